rr_dec_arbiter: RTL and testbench
=================================

// Module: rr_dec_arbiter
// PURPOSE
//  Round-robin arbiter sharing one 2-to-4 decoded resource among 4 requesters.
//  Selects a winner, holds the grant until release or timeout, and drives both
//  the 2-bit select (decoder input) and the one-hot grant (decoder output form).
//  Sits between requesting blocks and the shared decoder/enable path.
// PARAMETERS
//  MAX_HOLD  8  max consecutive cycles one grant may be held (legal: 1..255)
// PORTS
//  clk        in   1  rising-edge clock
//  rst_n      in   1  asynchronous active-low reset
//  req        in   4  request lines, req[i] from requester i, level-sensitive
//  done       in   1  holder finished; releases current grant (ignored if gnt_valid=0)
//  gnt_idx    out  2  index of current holder (decoder select)
//  gnt        out  4  one-hot grant: gnt_valid ? (4'b0001 << gnt_idx) : 4'b0000
//  gnt_valid  out  1  a grant is active
//  timeout    out  1  one-cycle pulse: grant was revoked by MAX_HOLD expiry
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, gnt_idx=0, gnt=0, gnt_valid=0,
//    timeout=0, ptr=0, hold_cnt=0. Deassertion takes effect on next edge.
//  - All outputs registered. gnt mapping: idx0->0001, idx1->0010, idx2->0100, idx3->1000.
//  - States: IDLE (no grant), BUSY (grant held).
//  - Arbitration: winner = first i with req[i]=1 scanning ptr, ptr+1, .. mod 4.
//    On each new grant: gnt_idx<=winner, ptr<=winner+1 (mod 4, wraps 3->0), hold_cnt<=0.
//  - IDLE: any req=1 at edge -> BUSY with winner; latency 1 clock req->gnt.
//    req=0000 -> stay IDLE, outputs unchanged (gnt_valid=0).
//  - BUSY: hold_cnt increments each cycle. Release condition at an edge:
//    (a) done=1, or (b) req[gnt_idx]=0, or (c) hold_cnt==MAX_HOLD-1.
//    gnt_valid therefore high at most MAX_HOLD consecutive cycles per grant.
//  - On release: re-arbitrate in same edge (zero dead cycles). Releasing holder
//    has lowest priority (ptr already past it); it is re-granted only if it is
//    the sole requester with req still high. No requester -> IDLE, gnt_valid=0.
//  - timeout<=1 for exactly one cycle only when release is due solely to (c);
//    if done=1 or req drop coincide with expiry, timeout stays 0.
//  - No release condition -> grant, gnt_idx, ptr unchanged; req changes of
//    non-holders have no effect until next arbitration.
//  - done while IDLE: ignored. Reset mid-grant: grant drops immediately
//    (asynchronously), ptr returns to 0.
//  - hold_cnt width 8 bits; never exceeds MAX_HOLD-1.
// TESTING
//  1 Reset: rst_n=0 during active grant -> gnt=0000, gnt_valid=0, gnt_idx=0 without clock edge.
//  2 req=0100 from IDLE -> next edge gnt=0100, gnt_idx=2, gnt_valid=1; done=1
//    one cycle -> next edge gnt_valid=0, timeout=0; ptr=3.
//  3 req=1111 held, done=1 every cycle after first grant -> grants 0,1,2,3,0
//    on consecutive edges, no gap cycles.
//  4 MAX_HOLD=4, req=0010 held, done=0 -> gnt=0010 for 4 cycles, timeout=1 one
//    cycle, req[1] sole requester so re-granted next cycle (gnt stays 0010).
//  5 MAX_HOLD=4, req=1010 with 1 holding, no done -> after 4 cycles timeout=1,
//    gnt=1000 (idx3) in same edge.
//  6 Holder drops req at cycle 2 with done=0 -> released next edge, timeout=0;
//    done=1 coinciding with expiry cycle -> timeout=0.

Source files
------------

// File: rtl/rr_dec_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// The master side drives requests; the slave side (the arbiter) returns the grant.
interface rr_dec_arbiter_if;
  logic [3:0] req;
  logic       done;
  logic [1:0] gnt_idx;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic       timeout;

  modport master (output req, output done,
                  input gnt_idx, input gnt, input gnt_valid, input timeout);
  modport slave  (input req, input done,
                  output gnt_idx, output gnt, output gnt_valid, output timeout);
endinterface

// File: rtl/rr_dec_arbiter.sv
// Round-robin arbiter for one shared 2-to-4 decoded resource among 4 requesters.
// Drives both the decoder select (gnt_idx) and the decoded one-hot grant.
module rr_dec_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  rr_dec_arbiter_if.slave   bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     r_state;
  logic [1:0] r_ptr;
  logic [7:0] r_hold_cnt;
  logic [1:0] r_gnt_idx;
  logic [3:0] r_gnt;
  logic       r_gnt_valid;
  logic       r_timeout;

  logic [3:0] w_rot;
  logic [1:0] w_off;
  logic [1:0] w_winner;
  logic       w_any;
  logic       w_expire;
  logic       w_release;
  logic       w_solo_expire;

  // Rotates the request vector so that bit 0 is the requester at ptr.
  function automatic logic [3:0] rotr4(input logic [3:0] v, input logic [1:0] s);
    logic [7:0] w;
    w = {v, v} >> s;
    return w[3:0];
  endfunction

  // Winner search from ptr plus the release conditions of the current holder.
  always_comb begin
    w_rot = rotr4(bus.req, r_ptr);
    w_off = 2'd0;
    casez (w_rot)
      4'b???1: w_off = 2'd0;
      4'b??10: w_off = 2'd1;
      4'b?100: w_off = 2'd2;
      4'b1000: w_off = 2'd3;
      default: w_off = 2'd0;
    endcase
    w_winner      = r_ptr + w_off;
    w_any         = |bus.req;
    w_expire      = (r_hold_cnt == HOLD_LAST);
    w_release     = bus.done || !bus.req[r_gnt_idx] || w_expire;
    // Expiry only counts as a timeout when nothing else would have released.
    w_solo_expire = w_expire && !bus.done && bus.req[r_gnt_idx];
  end

  // Grant FSM: every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= 2'd0;
      r_hold_cnt  <= 8'd0;
      r_gnt_idx   <= 2'd0;
      r_gnt       <= 4'b0000;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_timeout <= 1'b0;
          if (w_any) begin
            r_state     <= ST_BUSY;
            r_gnt_idx   <= w_winner;
            r_gnt       <= 4'b0001 << w_winner;
            r_gnt_valid <= 1'b1;
            r_ptr       <= w_winner + 2'd1;
            r_hold_cnt  <= 8'd0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (w_release) begin
            r_timeout <= w_solo_expire;
            // Re-arbitrate in the releasing edge; ptr already sits past the holder.
            if (w_any) begin
              r_state     <= ST_BUSY;
              r_gnt_idx   <= w_winner;
              r_gnt       <= 4'b0001 << w_winner;
              r_gnt_valid <= 1'b1;
              r_ptr       <= w_winner + 2'd1;
              r_hold_cnt  <= 8'd0;
            end else begin
              r_state     <= ST_IDLE;
              r_gnt       <= 4'b0000;
              r_gnt_valid <= 1'b0;
              r_hold_cnt  <= 8'd0;
            end
          end else begin
            r_timeout  <= 1'b0;
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_gnt       <= 4'b0000;
          r_gnt_valid <= 1'b0;
          r_timeout   <= 1'b0;
          r_hold_cnt  <= 8'd0;
        end
      endcase
    end
  end

  assign bus.gnt_idx   = r_gnt_idx;
  assign bus.gnt       = r_gnt;
  assign bus.gnt_valid = r_gnt_valid;
  assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_rr_dec_arbiter.sv
// Bench for rr_dec_arbiter: a cycle model of the grant rules is compared every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_rr_dec_arbiter;
  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_pass = 0;

  rr_dec_arbiter_if bus();

  rr_dec_arbiter #(.MAX_HOLD(MAX_HOLD)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model state: holder, how many cycles it has held, next scan start.
  bit m_valid;
  int m_idx;
  int m_held;
  int m_ptr;
  bit m_to;

  function automatic int next_winner(input logic [3:0] r, input int p);
    int  res;
    bit  found;
    res = -1;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!found && r[(p + k) % 4]) begin
        res = (p + k) % 4;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic bit must_release(input logic [3:0] r, input logic d);
    return m_valid && (d || !r[m_idx] || m_held == MAX_HOLD);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_idx   <= 0;
      m_held  <= 0;
      m_ptr   <= 0;
      m_to    <= 1'b0;
    end else if (!m_valid || must_release(bus.req, bus.done)) begin
      m_to <= m_valid && (m_held == MAX_HOLD) && !bus.done && bus.req[m_idx];
      if (next_winner(bus.req, m_ptr) >= 0) begin
        m_valid <= 1'b1;
        m_idx   <= next_winner(bus.req, m_ptr);
        m_ptr   <= (next_winner(bus.req, m_ptr) + 1) % 4;
        m_held  <= 1;
      end else begin
        m_valid <= 1'b0;
        m_held  <= 0;
      end
    end else begin
      m_held <= m_held + 1;
      m_to   <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("m_valid", 32'(bus.gnt_valid), 32'(m_valid));
      chk("m_gnt", 32'(bus.gnt), m_valid ? 32'(4'b0001 << m_idx) : 32'd0);
      chk("m_timeout", 32'(bus.timeout), 32'(m_to));
      if (m_valid) chk("m_idx", 32'(bus.gnt_idx), 32'(m_idx));
    end
  end

  task automatic cyc(input logic [3:0] r, input logic d);
    bus.req  = r;
    bus.done = d;
    @(negedge clk);
  endtask

  task automatic expect_grant(input string name, input logic [3:0] g, input logic [1:0] idx,
                              input logic to);
    chk({name, "_gnt"}, 32'(bus.gnt), 32'(g));
    chk({name, "_idx"}, 32'(bus.gnt_idx), 32'(idx));
    chk({name, "_valid"}, 32'(bus.gnt_valid), 32'd1);
    chk({name, "_to"}, 32'(bus.timeout), 32'(to));
  endtask

  initial begin
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_valid", 32'(bus.gnt_valid), 32'd0);
    chk("rst_idx", 32'(bus.gnt_idx), 32'd0);
    chk("rst_to", 32'(bus.timeout), 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Single requester, then done with req dropped.
    cyc(4'b0100, 1'b0);
    expect_grant("t2_grant", 4'b0100, 2'd2, 1'b0);
    cyc(4'b0000, 1'b1);
    chk("t2_rel_valid", 32'(bus.gnt_valid), 32'd0);
    chk("t2_rel_to", 32'(bus.timeout), 32'd0);
    chk("t2_model_ptr", 32'(m_ptr), 32'd3);
    cyc(4'b0000, 1'b1);
    chk("idle_done_valid", 32'(bus.gnt_valid), 32'd0);
    // ptr=3 so requester 0 beats requester 2.
    cyc(4'b0101, 1'b0);
    expect_grant("ptr_wrap", 4'b0001, 2'd0, 1'b0);

    // Asynchronous reset while a grant is active.
    #2 rst_n = 1'b0;
    bus.req = 4'b0000;
    #1;
    chk("t1_gnt", 32'(bus.gnt), 32'd0);
    chk("t1_valid", 32'(bus.gnt_valid), 32'd0);
    chk("t1_idx", 32'(bus.gnt_idx), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // All requesting, done every cycle: 0,1,2,3,0 back to back.
    cyc(4'b1111, 1'b0);
    expect_grant("t3_g0", 4'b0001, 2'd0, 1'b0);
    cyc(4'b1111, 1'b1);
    expect_grant("t3_g1", 4'b0010, 2'd1, 1'b0);
    cyc(4'b1111, 1'b1);
    expect_grant("t3_g2", 4'b0100, 2'd2, 1'b0);
    cyc(4'b1111, 1'b1);
    expect_grant("t3_g3", 4'b1000, 2'd3, 1'b0);
    cyc(4'b1111, 1'b1);
    expect_grant("t3_g4", 4'b0001, 2'd0, 1'b0);
    cyc(4'b0000, 1'b1);
    chk("t3_idle", 32'(bus.gnt_valid), 32'd0);

    // Sole requester held past MAX_HOLD: timeout then immediate re-grant.
    for (int i = 0; i < MAX_HOLD; i++) begin
      cyc(4'b0010, 1'b0);
      expect_grant("t4_hold", 4'b0010, 2'd1, 1'b0);
    end
    cyc(4'b0010, 1'b0);
    expect_grant("t4_expire", 4'b0010, 2'd1, 1'b1);
    cyc(4'b0010, 1'b0);
    expect_grant("t4_after", 4'b0010, 2'd1, 1'b0);
    cyc(4'b0000, 1'b0);
    chk("t4_idle", 32'(bus.gnt_valid), 32'd0);

    // Holder 1 with requester 3 waiting: expiry hands over to 3.
    cyc(4'b0010, 1'b0);
    expect_grant("t5_g1", 4'b0010, 2'd1, 1'b0);
    for (int i = 1; i < MAX_HOLD; i++) begin
      cyc(4'b1010, 1'b0);
      expect_grant("t5_hold", 4'b0010, 2'd1, 1'b0);
    end
    cyc(4'b1010, 1'b0);
    expect_grant("t5_handover", 4'b1000, 2'd3, 1'b1);

    // Holder drops its request: release without timeout.
    cyc(4'b1010, 1'b0);
    expect_grant("t6_hold", 4'b1000, 2'd3, 1'b0);
    cyc(4'b0010, 1'b0);
    expect_grant("t6_drop", 4'b0010, 2'd1, 1'b0);
    // done coinciding with expiry suppresses timeout.
    for (int i = 1; i < MAX_HOLD; i++) cyc(4'b0010, 1'b0);
    cyc(4'b0010, 1'b1);
    expect_grant("t6_done_exp", 4'b0010, 2'd1, 1'b0);
    cyc(4'b0000, 1'b0);
    chk("t6_idle", 32'(bus.gnt_valid), 32'd0);
    cyc(4'b0000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
